// File: rtl/frame_buf_pkg.sv
// Shared frame-buffer definitions: state encoding common to the writer and reader,
// default frame geometry and pixel width.
package frame_buf_pkg;

  localparam int FRAME_DEPTH = 76800;
  localparam int PX_W        = 15;

  typedef enum logic [1:0] {
    REQUESTING = 2'd0,
    WAIT_START = 2'd1,
    READING    = 2'd2,
    ENDING     = 2'd3
  } fb_state_t;

endpackage

// File: rtl/frame_reader_skid_fifo.sv
// Two-entry FIFO between the frame memory read port and the pixel stream.
// Flush empties it in one cycle; a push into a full FIFO without a pop is dropped.
module frame_reader_skid_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign pop_ok    = pop && (count != 2'd0);
  assign push_ok   = push && ((count != 2'd2) || pop_ok);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_reader_core.sv
// Frame reader: requests the shared frame buffer, sweeps addresses 0..DEPTH-1 and
// streams pixels on valid/ready. FRAME_READER_FRAME_CNT_EN adds a completed-frame counter.
module frame_reader_core
  import frame_buf_pkg::*;
#(
  parameter int DEPTH     = FRAME_DEPTH,
  parameter int ADDR_BITS = $clog2(DEPTH),
  parameter int DATA_W    = PX_W
) (
  input  logic                 px_clk_BUFG,
  input  logic                 reset,
  input  logic                 start_read,
  input  logic                 ack_read,
  output logic                 rq_read,
  output logic                 reading,
  output logic                 enable_mem,
  output logic [ADDR_BITS-1:0] read_addr,
  input  logic [DATA_W-1:0]    mem_data,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 frame_done,
`ifdef FRAME_READER_FRAME_CNT_EN
  output logic [15:0]          frame_count,
`endif
  output logic [1:0]           fsm_state
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  fb_state_t       state, state_nxt;
  logic            done_nxt;
  logic            issue, pop, flush, last_accept;
  logic            issue_done, inflight, inflight_last;
  logic [1:0]      fifo_count;
  logic [DATA_W:0] fifo_head;
  logic [2:0]      outstanding;

  // Handshake: a pixel transfers on a cycle with out_valid && out_ready; out_data and
  // out_last hold steady while out_valid is high and out_ready is low.
  assign out_valid   = (fifo_count != 2'd0);
  assign out_data    = fifo_head[DATA_W-1:0];
  assign out_last    = out_valid && fifo_head[DATA_W];
  assign pop         = out_valid && out_ready;
  assign last_accept = pop && fifo_head[DATA_W];
  assign flush       = (state == READING) && !ack_read;
  assign fsm_state   = state;

  // Credits count the slot freed by this cycle's pop, so a full-rate consumer sees no bubbles.
  always_comb begin
    outstanding = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    issue       = (state == READING) && ack_read && !issue_done && (outstanding < 3'd2);
  end

  assign enable_mem = issue;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      REQUESTING: if (ack_read) state_nxt = WAIT_START;
      WAIT_START: if (start_read) state_nxt = READING;
      READING: begin
        if (!ack_read) begin
          state_nxt = REQUESTING;
        end else if (last_accept) begin
          state_nxt = ENDING;
          done_nxt  = 1'b1;
        end
      end
      ENDING:     if (!ack_read) state_nxt = REQUESTING;
      default:    state_nxt = REQUESTING;
    endcase
  end

  always_ff @(posedge px_clk_BUFG or posedge reset) begin
    if (reset) begin
      state         <= REQUESTING;
      rq_read       <= 1'b0;
      reading       <= 1'b0;
      frame_done    <= 1'b0;
      read_addr     <= '0;
      issue_done    <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_nxt;
      rq_read       <= (state_nxt == REQUESTING);
      reading       <= (state_nxt == READING);
      frame_done    <= done_nxt;
      inflight      <= issue;
      inflight_last <= issue && (read_addr == LAST_ADDR);
      if ((state == WAIT_START) && start_read) begin
        read_addr  <= '0;
        issue_done <= 1'b0;
      end else if (issue) begin
        if (read_addr == LAST_ADDR) issue_done <= 1'b1;
        else                        read_addr  <= read_addr + 1'b1;
      end
    end
  end

`ifdef FRAME_READER_FRAME_CNT_EN
  always_ff @(posedge px_clk_BUFG or posedge reset) begin
    if (reset) frame_count <= 16'd0;
    else if (done_nxt) frame_count <= frame_count + 16'd1;
  end
`endif

  frame_reader_skid_fifo #(
    .W (DATA_W + 1)
  ) u_fifo (
    .clk       (px_clk_BUFG),
    .reset     (reset),
    .push      (inflight),
    .pop       (pop),
    .flush     (flush),
    .push_data ({inflight_last, mem_data}),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_frame_reader_core.sv
// Bench for frame_reader_core with DEPTH=8 and a memory returning 0x100 + addr.
// Expected pixels are queued per frame; a monitor pops and compares on each transfer.
module tb_frame_reader_core;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 15;

  logic          px_clk_BUFG = 1'b0;
  logic          reset       = 1'b1;
  logic          start_read  = 1'b0;
  logic          ack_read    = 1'b0;
  logic          rq_read, reading, enable_mem, out_valid, out_last, frame_done;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [1:0]    fsm_state;
`ifdef FRAME_READER_FRAME_CNT_EN
  logic [15:0]   frame_count;
`endif

  logic [DW:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int issued_cnt = 0;
  int acc_cnt = 0;
  int ready_mode = 3;
  int cyc = 0;
  int frames_ok = 0;

  frame_reader_core #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .px_clk_BUFG (px_clk_BUFG),
    .reset       (reset),
    .start_read  (start_read),
    .ack_read    (ack_read),
    .rq_read     (rq_read),
    .reading     (reading),
    .enable_mem  (enable_mem),
    .read_addr   (read_addr),
    .mem_data    (mem_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .frame_done  (frame_done),
`ifdef FRAME_READER_FRAME_CNT_EN
    .frame_count (frame_count),
`endif
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 px_clk_BUFG = ~px_clk_BUFG;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // Synchronous RAM model with one cycle of read latency.
  always @(posedge px_clk_BUFG) begin
    if (enable_mem) mem_data <= DW'(15'h100 + 15'(read_addr));
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge px_clk_BUFG);
    #1;
  endtask

  always @(posedge px_clk_BUFG) begin
    cyc <= cyc + 1;
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rq_read"}, 32'(rq_read), 0);
    check({tag, "_reading"}, 32'(reading), 0);
    check({tag, "_enable_mem"}, 32'(enable_mem), 0);
    check({tag, "_read_addr"}, 32'(read_addr), 0);
    check({tag, "_out_data"}, 32'(out_data), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_last"}, 32'(out_last), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_state"}, 32'(fsm_state), 0);
`ifdef FRAME_READER_FRAME_CNT_EN
    check({tag, "_frame_count"}, 32'(frame_count), 0);
`endif
  endtask

  task automatic grant();
    bit seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (rq_read) begin seen = 1; break; end
      step();
    end
    check("grant_rq_seen", 32'(seen), 1);
    ack_read = 1'b1;
    step();
    check("grant_rq_drop", 32'(rq_read), 0);
    check("grant_state", 32'(fsm_state), 1);
    check("grant_no_mem", 32'(enable_mem), 0);
  endtask

  task automatic queue_frame();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), DW'(32'h100 + i)});
    issued_cnt = 0;
    acc_cnt    = 0;
  endtask

  task automatic pulse_start();
    start_read = 1'b1;
    step();
    start_read = 1'b0;
  endtask

  // Runs one frame to completion; expects the FSM in WAIT_START.
  task automatic run_frame(input bit timed, input bit noisy);
    int done_c = -1;
    int first_c = -1;
    queue_frame();
    pulse_start();
    check("frame_reading_high", 32'(reading), 1);
    for (int c = 0; c < 300; c++) begin
      @(negedge px_clk_BUFG);
      if (out_valid && first_c < 0) first_c = c;
      if (frame_done) begin done_c = c; break; end
      step();
      if (noisy) start_read = ($urandom_range(0, 3) == 0);
    end
    start_read = 1'b0;
    if (done_c < 0) begin
      n_vec++; n_bad++;
      $display("FAIL frame_timeout: got no frame_done, required frame_done");
    end else begin
      frames_ok++;
      if (timed) begin
        check("first_valid_latency", 32'(first_c), 2);
        check("frame_done_latency", 32'(done_c), DEPTH + 2);
      end
      check("done_queue_drained", 32'(exp_q.size()), 0);
      check("done_reading_low", 32'(reading), 0);
      check("done_state", 32'(fsm_state), 3);
      check("done_out_valid", 32'(out_valid), 0);
      @(negedge px_clk_BUFG);
      check("done_one_pulse", 32'(frame_done), 0);
    end
    step();
    ack_read = 1'b0;
    step();
    check("release_rq_read", 32'(rq_read), 1);
    check("release_state", 32'(fsm_state), 0);
  endtask

  task automatic wait_acc(input int n);
    bit hit = 0;
    for (int c = 0; c < 200; c++) begin
      if (acc_cnt >= n) begin hit = 1; break; end
      step();
    end
    check("wait_accepted", 32'(hit), 1);
  endtask

  task automatic abort_frame(input int after);
    bit pulse = 0;
    ready_mode = 3;
    out_ready  = 1'b1;
    queue_frame();
    pulse_start();
    wait_acc(after);
    ack_read  = 1'b0;
    out_ready = 1'b0;
    step();
    exp_q.delete();
    @(negedge px_clk_BUFG);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_reading", 32'(reading), 0);
    check("abort_rq_read", 32'(rq_read), 1);
    check("abort_state", 32'(fsm_state), 0);
    check("abort_accepted", 32'(acc_cnt), after);
    for (int c = 0; c < 4; c++) begin
      if (frame_done) pulse = 1;
      @(negedge px_clk_BUFG);
    end
    check("abort_no_frame_done", 32'(pulse), 0);
    step();
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [DW:0] e;
    logic [DW-1:0] held;
    bit stalled = 0;
    forever begin
      @(negedge px_clk_BUFG);
      if (reset) begin
        stalled = 0;
      end else begin
        if (stalled && out_valid) check("stall_data_stable", 32'(out_data), 32'(held));
        if (out_valid && out_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_pixel: got %0h required none", out_data);
          end else begin
            e = exp_q.pop_front();
            check("pixel", {16'd0, out_last, out_data}, {16'd0, e});
          end
        end
        if (enable_mem) begin
          check("issue_addr", 32'(read_addr), 32'(issued_cnt));
          issued_cnt++;
          n_vec++;
          if (issued_cnt - acc_cnt > 2) begin
            n_bad++;
            $display("FAIL outstanding: got %0d required <= 2", issued_cnt - acc_cnt);
          end
        end
        stalled = out_valid && !out_ready;
        held    = out_data;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge px_clk_BUFG);
    #3 reset = 1'b0;
    step();
    // ack held low: request stays up, nothing issued.
    for (int c = 0; c < 3; c++) begin
      check("req_hold", 32'(rq_read), 1);
      check("req_no_mem", 32'(enable_mem), 0);
      step();
    end
    // start_read outside WAIT_START is ignored.
    start_read = 1'b1;
    step();
    step();
    start_read = 1'b0;
    check("ignore_start_state", 32'(fsm_state), 0);
    check("ignore_start_mem", 32'(enable_mem), 0);

    grant();
    ready_mode = 0;
    run_frame(1, 0);

    grant();
    ready_mode = 1;
    run_frame(0, 0);

    grant();
    abort_frame(3);
    grant();
    ready_mode = 0;
    run_frame(1, 0);

    // Asynchronous reset at pixel 5.
    grant();
    ready_mode = 3;
    out_ready  = 1'b1;
    queue_frame();
    pulse_start();
    wait_acc(5);
    reset    = 1'b1;
    ack_read = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    frames_ok = 0;
    step();
    step();
    reset = 1'b0;
    step();
    check("post_reset_rq", 32'(rq_read), 1);

    for (int f = 0; f < 3; f++) begin
      grant();
      repeat ($urandom_range(0, 3)) step();
      ready_mode = 2;
      run_frame(0, 1);
    end
    grant();
    abort_frame(2);
`ifdef FRAME_READER_FRAME_CNT_EN
    check("frame_count", 32'(frame_count), 32'(frames_ok % 65536));
`endif
    grant();
    ready_mode = 0;
    run_frame(1, 0);
`ifdef FRAME_READER_FRAME_CNT_EN
    check("frame_count_final", 32'(frame_count), 32'(frames_ok % 65536));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_reader_core.md
Name: frame_reader_core

Overview:
- Read-side counterpart of the grayscale frame writer.
- Arbitrates for the shared frame buffer with an rq_read/ack_read handshake, then waits for a start trigger.
- Sweeps read addresses 0..DEPTH-1 and streams the 15-bit pixels out on a valid/ready interface with full backpressure. Intended consumers: display or DMA path.
- Frame memory has a fixed 1-cycle synchronous read latency.

Parameters:
- DEPTH, 76800, pixels per frame (320x240).
- ADDR_BITS, $clog2(DEPTH), width of read_addr.
- DATA_W, 15, pixel width (RGB555 or replicated grayscale).

Ports:
- px_clk_BUFG  in  1  pixel clock, already buffered; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- start_read  in  1  frame start trigger, sampled only in WAIT_START.
- ack_read  in  1  arbiter grant.
- rq_read  out  1  access request to arbiter.
- reading  out  1  high while frame sweep is active.
- enable_mem  out  1  memory read enable; high only on cycles that issue an address.
- read_addr  out  ADDR_BITS  memory read address.
- mem_data  in  DATA_W  memory read data, valid the cycle after enable_mem.
- out_data  out  DATA_W  pixel.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_last  out  1  marks pixel DEPTH-1, qualified by out_valid.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
Reset values: all outputs 0; read_addr = 0; state REQUESTING; buffer empty; in-flight flag 0.

FSM:
- REQUESTING: drive rq_read = 1. On ack_read = 1, drop rq_read and go to WAIT_START.
- WAIT_START: on start_read = 1, set reading = 1, read_addr = 0, go to READING.
- READING: issue addresses, then drain the buffer.
  - Issue rule: issue when (occupancy + inflight) < 2 and issued count < DEPTH.
  - Issue cycle: enable_mem = 1, read_addr presented; read_addr increments after the issue.
  - Capture: mem_data is written into a 2-entry FIFO the following cycle.
  - Leave READING when all DEPTH pixels have been accepted downstream: go to ENDING, reading = 0, frame_done = 1 for one cycle.
- ENDING: wait for ack_read = 0, then go to REQUESTING.

Output stream:
- out_valid = FIFO not empty; out_data = FIFO head; no combinational path from mem_data.
- Latency: first out_valid appears 2 cycles after the READING entry cycle.
- With out_ready held high: sustained 1 pixel/cycle, no bubbles.
- out_last is asserted on the pixel read from address DEPTH-1.
- Data must stay stable while out_valid && !out_ready (AXI-stream rule).

Boundaries:
- FIFO never overflows; the credit rule guarantees this.
- read_addr stops at DEPTH-1 and does not wrap within a frame.
- ack_read dropping during READING is an abort:
  - stop issuing; discard in-flight data; flush the FIFO;
  - out_valid = 0 next cycle; reading = 0; no frame_done;
  - go to REQUESTING.
- start_read while not in WAIT_START is ignored.
- Same-cycle FIFO push and pop keeps occupancy constant.
- Asynchronous reset mid-frame: everything returns to reset values immediately.

Optional Feature:
- Macro: FRAME_READER_FRAME_CNT_EN.
- Defined: adds output port frame_count (16 bits, reset 0). It increments on each frame_done pulse, wraps at 65535->0, and does not increment on an aborted frame.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package frame_buf_pkg:
  - state encoding constants REQUESTING=0, WAIT_START=1, READING=2, ENDING=3 (same encoding the writer uses for its states);
  - FRAME_DEPTH = 76800;
  - PX_W = 15.
- One sub-module: frame_reader_skid_fifo, a 2-entry FIFO (push, pop, flush, data, count), kept separate so it can be unit-tested on its own.

Test Plan (DEPTH=8, memory model returns data = 0x100 + addr):
- Grant flow: hold ack_read low -> rq_read = 1 stays high; raise ack_read -> rq_read = 0 next cycle, state WAIT_START, no enable_mem.
- Full frame, out_ready = 1: pulse start_read -> out_data 0x100..0x107 on 8 consecutive cycles; out_last only with 0x107; frame_done one cycle later; reading falls.
- Backpressure, out_ready toggled 1,0,0,1,... -> all 8 pixels delivered in order, none duplicated or lost; out_data stable while stalled; never more than 2 addresses outstanding.
- Abort: drop ack_read after 3 pixels accepted -> out_valid = 0 next cycle, no frame_done, rq_read = 1 again; the next frame restarts at address 0.
- Reset mid-frame at pixel 5 -> all outputs 0 asynchronously; after release rq_read = 1 and a clean frame follows.
- FRAME_READER_FRAME_CNT_EN defined: 3 complete frames plus 1 aborted -> frame_count = 3.
